obstacle_scheduler: RTL and testbench
=====================================

Name: obstacle_scheduler

Overview:
Owns the pool of NUM_OBS obstacle sprite slots: spawns new obstacles at pseudo-random x positions, advances them down the screen once per frame, and retires them off-screen. It also clears the whole pool when a collision is signalled. Outputs drive the sprite instances' sprite_x, sprite_y and en inputs directly. Sits between the display_480p frame strobe / collision detector and the obstacle sprite array, replacing the fixed-offset asteroid movement.

Parameters:
NUM_OBS, 10, number of obstacle slots (1..16)
SCREEN_CORDW, 16, coordinate width
H_RES, 640, visible width
V_RES, 480, visible height
OBS_SIZE, 40, rendered obstacle edge in pixels (sprite WIDTH*SCALE)
SPAWN_FRAMES, 30, enabled frames between spawn attempts (>=1)
SPEED_Y, 3, pixels moved down per enabled frame
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clk_pix  in  1  pixel clock; all state on its rising edge
reset_n  in  1  asynchronous active-low reset
frame  in  1  one-cycle start-of-frame strobe from display_480p
en  in  1  obstacles enabled (SW[9])
clear  in  1  collision/clear request, level, sampled each cycle
obs_x  out  NUM_OBS x SCREEN_CORDW  per-slot x position
obs_y  out  NUM_OBS x SCREEN_CORDW  per-slot y position
obs_active  out  NUM_OBS  per-slot valid; used as sprite en
active_count  out  5  number of active slots
busy  out  1  high while in UPDATE or SPAWN

Behaviour:
- Reset: obs_x, obs_y, obs_active = 0; active_count = 0; busy = 0; state = IDLE; spawn_cnt = 0; slot index = 0; LFSR = LFSR_SEED.
- FSM states: IDLE, UPDATE, SPAWN. All outputs are registered.
- IDLE: if frame && en, go to UPDATE with idx = 0. If frame && !en, do nothing; positions and spawn_cnt are frozen.
- UPDATE: processes one slot per cycle, slot idx.
  - If the slot is active: y_next = obs_y + SPEED_Y, computed at SCREEN_CORDW+1 bits.
  - If y_next >= V_RES, the slot retires: obs_active = 0, obs_y = 0. Otherwise obs_y = y_next.
  - Inactive slots are untouched.
  - At idx == NUM_OBS-1, go to SPAWN; otherwise idx++.
- SPAWN (one cycle):
  - If spawn_cnt == SPAWN_FRAMES-1: spawn_cnt = 0, and the lowest-index inactive slot (priority encoder) is loaded with obs_active = 1, obs_y = 0, obs_x = xr. The LFSR advances one step only on a successful load.
  - If no slot is free, the spawn is dropped, spawn_cnt still returns to 0, and the LFSR holds.
  - Otherwise spawn_cnt++.
  - active_count is updated to the popcount after the spawn. Return to IDLE.
- xr derivation: xr = LFSR[XW-1:0] with XW = clog2(H_RES); if xr >= H_RES-OBS_SIZE, then xr -= H_RES-OBS_SIZE. Elaboration asserts 2^XW < 2*(H_RES-OBS_SIZE).
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), shift right.
- Latency: frame to first slot updated is 1 cycle. The full walk completes NUM_OBS+1 cycles after frame. A newly spawned slot first moves on the next enabled frame.
- frame during busy is ignored. This cannot occur under legal timing, and the bench asserts it.
- en dropping mid-walk: the walk and SPAWN complete; the gate applies only at IDLE.
- clear has highest priority in every state. On the next edge: all obs_active = 0, obs_y = 0, active_count = 0, spawn_cnt = 0, state = IDLE, busy = 0. obs_x and the LFSR are kept, so the spawn pattern differs after each collision. clear held high keeps the pool empty.
- clear and frame in the same cycle: clear wins and the frame is discarded.

Decomposition:
- Shared package game_pkg:
  - SCREEN_CORDW, H_RES, V_RES
  - sched_state_t enum {IDLE, UPDATE, SPAWN}
  - LFSR16_MASK constant
  - coord_t typedef
- One sub-module, lfsr16, with ports clk_pix, reset_n, step, seed param, and value out.
- Priority encoder and popcount are functions in game_pkg.

Test Plan:
- Reset: hold reset_n low mid-walk -> all outputs 0 asynchronously, busy 0. After release, 29 enabled frames give active_count 0.
- First spawn: en=1, 30 frames -> after the 30th frame's SPAWN, obs_active=1 and obs_x[0]=225 (16'hACE1[9:0]=225 < 600), obs_y[0]=0. Frame 31 -> obs_y[0]=3, with busy high for exactly 11 cycles.
- Retire: force slot 0 to y=477 -> next enabled frame gives obs_active[0]=0, obs_y[0]=0, and active_count drops by 1. Force y=476 -> y=479 and the slot stays active.
- Full pool: SPAWN_FRAMES=1, NUM_OBS=10, 11 frames -> 10 active in slots 0..9 with x from successive LFSR values, all <600. The 11th spawn is dropped, the LFSR is unchanged, and spawn_cnt is 0.
- Clear: assert clear at idx=4 of a walk with 6 active -> next cycle obs_active=0, active_count=0, state IDLE. clear+frame in the same cycle -> no walk starts.
- Disable: en=0 for 50 frames -> obs_y and spawn_cnt are unchanged and busy never rises. en=1 then resumes from the frozen spawn_cnt.

Source files
------------

// File: rtl/game_pkg.sv
// Shared screen geometry, scheduler state encoding and small combinational helpers
// used by the obstacle scheduler and its LFSR.
package game_pkg;

    localparam int SCREEN_CORDW = 16;
    localparam int H_RES        = 640;
    localparam int V_RES        = 480;

    localparam logic [15:0] LFSR16_MASK = 16'hB400;

    typedef logic [SCREEN_CORDW-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        SPAWN
    } sched_state_t;

    // Index of the lowest zero bit; 16 when every bit is set.
    function automatic logic [4:0] lowest_clear16(input logic [15:0] v);
        logic [4:0] pos;
        pos = 5'd16;
        for (int i = 15; i >= 0; i--) begin
            if (!v[i]) pos = 5'(i);
        end
        return pos;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Frame/enable/clear controls into the scheduler and the per-slot sprite
// position and enable bus out of it.
interface obstacle_scheduler_if #(
    parameter int NUM_OBS = 10,
    parameter int CORDW   = 16
);
    logic                              frame;
    logic                              en;
    logic                              clear;
    logic [NUM_OBS-1:0][CORDW-1:0]     obs_x;
    logic [NUM_OBS-1:0][CORDW-1:0]     obs_y;
    logic [NUM_OBS-1:0]                obs_active;
    logic [4:0]                        active_count;
    logic                              busy;

    modport master (
        output frame, en, clear,
        input  obs_x, obs_y, obs_active, active_count, busy
    );

    modport slave (
        input  frame, en, clear,
        output obs_x, obs_y, obs_active, active_count, busy
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR, advances one step per cycle that step is high.
// Latency: new value visible the cycle after step; no backpressure.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_pix,
    input  logic        reset_n,
    input  logic        step,
    output logic [15:0] value
);
    import game_pkg::*;

    if (SEED == 16'h0000) begin : g_bad_seed
        $error("lfsr16: an all-zero seed locks the LFSR");
    end

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            value <= SEED;
        end else if (step) begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR16_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle pool: per enabled frame walks one slot/cycle (NUM_OBS cycles) then one SPAWN cycle.
// Latency: walk done NUM_OBS+1 cycles after frame; no backpressure, frames while busy are ignored.
module obstacle_scheduler #(
    parameter int          NUM_OBS      = 10,
    parameter int          SCREEN_CORDW = game_pkg::SCREEN_CORDW,
    parameter int          H_RES        = game_pkg::H_RES,
    parameter int          V_RES        = game_pkg::V_RES,
    parameter int          OBS_SIZE     = 40,
    parameter int          SPAWN_FRAMES = 30,
    parameter int          SPEED_Y      = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk_pix,
    input  logic                 reset_n,
    obstacle_scheduler_if.slave  bus
);
    import game_pkg::*;

    localparam int IW   = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam int XW   = $clog2(H_RES);
    localparam int XMAX = H_RES - OBS_SIZE;
    localparam int SCW  = $clog2(SPAWN_FRAMES) + 1;
    localparam int YW   = SCREEN_CORDW + 1;

    // A single conditional subtract only folds the LFSR field into range if it spans < 2 windows.
    if ((1 << XW) >= 2 * XMAX) begin : g_bad_xrange
        $error("obstacle_scheduler: 2**clog2(H_RES) must be below 2*(H_RES-OBS_SIZE)");
    end
    if (NUM_OBS < 1 || NUM_OBS > 16) begin : g_bad_num_obs
        $error("obstacle_scheduler: NUM_OBS must be 1..16");
    end
    if (SPAWN_FRAMES < 1) begin : g_bad_spawn
        $error("obstacle_scheduler: SPAWN_FRAMES must be at least 1");
    end

    sched_state_t                          state;
    logic [IW-1:0]                         idx;
    logic [SCW-1:0]                        spawn_cnt;
    logic [NUM_OBS-1:0][SCREEN_CORDW-1:0]  x_q;
    logic [NUM_OBS-1:0][SCREEN_CORDW-1:0]  y_q;
    logic [NUM_OBS-1:0]                    act_q;
    logic [4:0]                            count_q;
    logic                                  busy_q;
    logic [15:0]                           lfsr_val;

    logic [YW-1:0]       y_next;
    logic                retire;
    logic [15:0]         act16;
    logic [15:0]         after16;
    logic [4:0]          free_pos;
    logic                has_free;
    logic [IW-1:0]       slot;
    logic                spawn_due;
    logic                do_load;
    logic [NUM_OBS-1:0]  act_after;
    logic [XW-1:0]       xr_raw;
    logic [XW-1:0]       xr;
    logic                spare_unused;

    assign y_next = {1'b0, y_q[idx]} + YW'(SPEED_Y);
    assign retire = (y_next >= YW'(V_RES));

    // Slots beyond NUM_OBS read as occupied so the encoder never picks them.
    always_comb begin
        act16                = '1;
        act16[NUM_OBS-1:0]   = act_q;
    end

    assign free_pos  = lowest_clear16(act16);
    assign has_free  = ~free_pos[4];
    assign slot      = free_pos[IW-1:0];
    assign spawn_due = (spawn_cnt == SCW'(SPAWN_FRAMES - 1));
    assign do_load   = (state == SPAWN) && spawn_due && has_free && !bus.clear;

    always_comb begin
        act_after = act_q;
        if (spawn_due && has_free) act_after[slot] = 1'b1;
    end

    always_comb begin
        after16              = '0;
        after16[NUM_OBS-1:0] = act_after;
    end

    assign xr_raw = lfsr_val[XW-1:0];
    assign xr     = (xr_raw >= XW'(XMAX)) ? (xr_raw - XW'(XMAX)) : xr_raw;

    assign spare_unused = &{1'b0, free_pos, lfsr_val};

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_pix (clk_pix),
        .reset_n (reset_n),
        .step    (do_load),
        .value   (lfsr_val)
    );

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            spawn_cnt <= '0;
            x_q       <= '0;
            y_q       <= '0;
            act_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else if (bus.clear) begin
            // Collision: empty the pool but keep x and the LFSR so the next pattern differs.
            state     <= IDLE;
            idx       <= '0;
            spawn_cnt <= '0;
            y_q       <= '0;
            act_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.frame && bus.en) begin
                        state  <= UPDATE;
                        idx    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                UPDATE: begin
                    if (act_q[idx]) begin
                        if (retire) begin
                            act_q[idx] <= 1'b0;
                            y_q[idx]   <= '0;
                        end else begin
                            y_q[idx]   <= y_next[SCREEN_CORDW-1:0];
                        end
                    end
                    if (idx == IW'(NUM_OBS - 1)) begin
                        state <= SPAWN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SPAWN: begin
                    if (spawn_due) begin
                        spawn_cnt <= '0;
                        if (has_free) begin
                            act_q[slot] <= 1'b1;
                            y_q[slot]   <= '0;
                            x_q[slot]   <= SCREEN_CORDW'(xr);
                        end
                    end else begin
                        spawn_cnt <= spawn_cnt + 1'b1;
                    end
                    count_q <= popcount16(after16);
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.obs_x        = x_q;
    assign bus.obs_y        = y_q;
    assign bus.obs_active   = act_q;
    assign bus.active_count = count_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Drives a default scheduler and a spawn-every-frame scheduler with shared controls,
// checking both against a slot-pool reference model after every frame.
module tb_obstacle_scheduler;

    localparam int N = 10;
    localparam int W = 160;

    logic clk_pix = 1'b0;
    logic reset_n = 1'b0;
    logic frame, en, clear;

    always #5 clk_pix = ~clk_pix;

    obstacle_scheduler_if #(.NUM_OBS(N)) ifc_m ();
    obstacle_scheduler_if #(.NUM_OBS(N)) ifc_f ();

    assign ifc_m.frame = frame;
    assign ifc_m.en    = en;
    assign ifc_m.clear = clear;
    assign ifc_f.frame = frame;
    assign ifc_f.en    = en;
    assign ifc_f.clear = clear;

    obstacle_scheduler #(.NUM_OBS(N)) u_main (
        .clk_pix (clk_pix),
        .reset_n (reset_n),
        .bus     (ifc_m)
    );

    obstacle_scheduler #(.NUM_OBS(N), .SPAWN_FRAMES(1)) u_fast (
        .clk_pix (clk_pix),
        .reset_n (reset_n),
        .bus     (ifc_f)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference pool: index 0 models u_main, index 1 models u_fast.
    int          m_x   [2][N];
    int          m_y   [2][N];
    bit          m_act [2][N];
    int          m_cnt [2];
    logic [15:0] m_lfsr[2];
    int          sf    [2] = '{30, 1};

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic int xr_of(input logic [15:0] l);
        int v;
        v = int'(l[9:0]);
        if (v >= 600) v = v - 600;
        return v;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_cnt[m]  = 0;
            m_lfsr[m] = 16'hACE1;
            for (int i = 0; i < N; i++) begin
                m_x[m][i] = 0; m_y[m][i] = 0; m_act[m][i] = 1'b0;
            end
        end
    endfunction

    function automatic void model_clear();
        for (int m = 0; m < 2; m++) begin
            m_cnt[m] = 0;
            for (int i = 0; i < N; i++) begin
                m_y[m][i] = 0; m_act[m][i] = 1'b0;
            end
        end
    endfunction

    function automatic void model_frame(input int m);
        int f;
        for (int i = 0; i < N; i++) begin
            if (m_act[m][i]) begin
                if (m_y[m][i] + 3 >= 480) begin
                    m_act[m][i] = 1'b0;
                    m_y[m][i]   = 0;
                end else begin
                    m_y[m][i] = m_y[m][i] + 3;
                end
            end
        end
        if (m_cnt[m] == sf[m] - 1) begin
            m_cnt[m] = 0;
            f = -1;
            for (int i = N - 1; i >= 0; i--) if (!m_act[m][i]) f = i;
            if (f >= 0) begin
                m_act[m][f] = 1'b1;
                m_y[m][f]   = 0;
                m_x[m][f]   = xr_of(m_lfsr[m]);
                m_lfsr[m]   = lfsr_next(m_lfsr[m]);
            end
        end else begin
            m_cnt[m] = m_cnt[m] + 1;
        end
    endfunction

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            logic [N-1:0][15:0] ex, ey, ox, oy;
            logic [N-1:0]       ea, oa;
            logic [4:0]         oc;
            logic               ob;
            int                 c;
            string              p;
            c = 0;
            for (int i = 0; i < N; i++) begin
                ex[i] = 16'(m_x[m][i]);
                ey[i] = 16'(m_y[m][i]);
                ea[i] = m_act[m][i];
                c     = c + int'(m_act[m][i]);
            end
            if (m == 0) begin
                p = "main"; ox = ifc_m.obs_x; oy = ifc_m.obs_y; oa = ifc_m.obs_active;
                oc = ifc_m.active_count; ob = ifc_m.busy;
            end else begin
                p = "fast"; ox = ifc_f.obs_x; oy = ifc_f.obs_y; oa = ifc_f.obs_active;
                oc = ifc_f.active_count; ob = ifc_f.busy;
            end
            check({p, "_obs_x"},        W'(ox), W'(ex));
            check({p, "_obs_y"},        W'(oy), W'(ey));
            check({p, "_obs_active"},   W'(oa), W'(ea));
            check({p, "_active_count"}, W'(oc), W'(c));
            check({p, "_busy_idle"},    W'(ob), W'(0));
        end
    endtask

    // clr_at: -1 none, -2 clear together with frame, >=0 clear while slot clr_at is processed.
    task automatic frame_step(input bit en_v, input int clr_at);
        int nb;
        bit cut;
        nb  = 0;
        cut = 1'b0;
        check("frame_while_busy", W'(ifc_m.busy), W'(0));
        en    = en_v;
        frame = 1'b1;
        if (clr_at == -2) clear = 1'b1;
        tick();
        frame = 1'b0;
        if (clr_at == -2) begin
            clear = 1'b0;
            model_clear();
            check("clear_frame_busy", W'(ifc_m.busy), W'(0));
        end else if (!en_v) begin
            check("disabled_busy", W'(ifc_m.busy), W'(0));
        end else begin
            while (ifc_m.busy && nb < 20) begin
                if (nb == clr_at) begin
                    clear = 1'b1;
                    tick();
                    clear = 1'b0;
                    model_clear();
                    cut = 1'b1;
                    break;
                end
                tick();
                nb++;
            end
            if (cut) begin
                check("clear_walk_busy", W'(ifc_m.busy), W'(0));
            end else begin
                check("busy_len", W'(nb), W'(11));
                model_frame(0);
                model_frame(1);
            end
        end
        repeat ($urandom_range(1, 4)) tick();
        compare_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c189;
        frame = 1'b0; en = 1'b0; clear = 1'b0;
        model_reset();
        #12;
        compare_all();
        reset_n = 1'b1;
        tick();

        // Two frames, then reset lands in the middle of a walk.
        en = 1'b1;
        frame_step(1'b1, -1);
        frame_step(1'b1, -1);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        #3 reset_n = 1'b1;
        tick();

        for (int f = 1; f <= 31; f++) begin
            frame_step(1'b1, -1);
            if (f == 10) begin
                check("fast_full_count", W'(ifc_f.active_count), W'(10));
                for (int i = 0; i < N; i++)
                    check("fast_x_in_range", W'(ifc_f.obs_x[i] < 16'd600), W'(1));
            end
            if (f == 11) check("fast_drop_count", W'(ifc_f.active_count), W'(10));
            if (f == 29) check("main_pre_spawn_count", W'(ifc_m.active_count), W'(0));
            if (f == 30) begin
                check("first_spawn_active", W'(ifc_m.obs_active), W'(1));
                check("first_spawn_x", W'(ifc_m.obs_x[0]), W'(225));
                check("first_spawn_y", W'(ifc_m.obs_y[0]), W'(0));
            end
            if (f == 31) check("first_move_y", W'(ifc_m.obs_y[0]), W'(3));
        end

        for (int f = 32; f <= 189; f++) frame_step(1'b1, -1);
        check("y477_still_active", W'(ifc_m.obs_active[0]), W'(1));
        check("y477_value", W'(ifc_m.obs_y[0]), W'(477));
        c189 = int'(ifc_m.active_count);
        frame_step(1'b1, -1);
        check("retire_active", W'(ifc_m.obs_active[0]), W'(0));
        check("retire_y", W'(ifc_m.obs_y[0]), W'(0));
        check("retire_count", W'(ifc_m.active_count), W'(c189 - 1));

        for (int f = 191; f <= 210; f++) frame_step(1'b1, -1);
        check("six_active", W'(ifc_m.active_count), W'(6));
        frame_step(1'b1, 4);
        check("clear_walk_active", W'(ifc_m.obs_active), W'(0));
        check("clear_walk_count", W'(ifc_m.active_count), W'(0));
        frame_step(1'b1, -2);

        for (int f = 0; f < 50; f++) frame_step(1'b0, -1);
        for (int f = 0; f < 40; f++) frame_step(1'b1, -1);

        for (int f = 0; f < 150; f++) begin
            int r;
            int ca;
            r  = int'($urandom_range(0, 29));
            ca = (r == 0) ? -2 : (r == 1) ? int'($urandom_range(0, 10)) : -1;
            frame_step($urandom_range(0, 9) != 0, ca);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
